// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with the MEM/WB register: issues loads/stores on a req/ack
// data bus, aligns load data and stalls the upstream pipe while an access is outstanding.
module mem_stage_lsu #(
   parameter int DATA_WIDTH          = 32,
   parameter int INST_WIDTH          = 32,
   parameter int REGISTER_ADDR_WIDTH = 5,
   parameter int ACK_TIMEOUT         = 255
) (
   input  logic                           cpu_clk,
   input  logic                           cpu_rst_n,
   input  logic [INST_WIDTH-1:0]          INST_MEM_i,
   input  logic                           reg_write_MEM_i,
   input  logic                           mem_write_MEM_i,
   input  logic [1:0]                     result_sel_MEM_i,
   input  logic [DATA_WIDTH-1:0]          alu_res_MEM_i,
   input  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_i,
   input  logic [DATA_WIDTH-1:0]          write_data_MEM_i,
   input  logic [DATA_WIDTH-1:0]          PC_plus_4_MEM_i,
   output logic                           mem_stall_o,
   output logic                           dmem_req_o,
   output logic                           dmem_we_o,
   output logic [DATA_WIDTH-1:0]          dmem_addr_o,
   output logic [DATA_WIDTH-1:0]          dmem_wdata_o,
   output logic [3:0]                     dmem_wstrb_o,
   input  logic                           dmem_ack_i,
   input  logic [DATA_WIDTH-1:0]          dmem_rdata_i,
   output logic                           lsu_fault_o,
   output logic                           dmem_err_o,
   output logic [INST_WIDTH-1:0]          INST_MEM_WB_o,
   output logic                           reg_write_MEM_WB_o,
   output logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB_o,
   output logic [DATA_WIDTH-1:0]          wb_data_MEM_WB_o
);

   localparam int TIMER_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(ACK_TIMEOUT);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Unsigned sizes exist only for loads; anything else is illegal.
   function automatic logic f_funct3_ok(input logic [2:0] f3, input logic store);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         F3_H, F3_HU: mis = off[0];
         F3_W:        mis = (off != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] f_store_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] strb;
      case (f3)
         F3_B:    strb = 4'b0001 << off;
         F3_H:    strb = 4'b0011 << off;
         F3_W:    strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_store_data(input logic [2:0] f3,
                                                          input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] w;
      case (f3)
         F3_B:    w = {4{d[7:0]}};
         F3_H:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_load_data(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] rdata,
                                                         input logic [1:0] off);
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] v;
      sh = rdata >> {off, 3'b000};
      case (f3)
         F3_B:    v = {{24{sh[7]}}, sh[7:0]};
         F3_H:    v = {{16{sh[15]}}, sh[15:0]};
         F3_W:    v = sh;
         F3_BU:   v = {24'h000000, sh[7:0]};
         F3_HU:   v = {16'h0000, sh[15:0]};
         default: v = {DATA_WIDTH{1'b0}};
      endcase
      return v;
   endfunction

   state_t                         state_r, state_n_s;
   logic [TIMER_W-1:0]             timer_r, timer_n_s;
   logic                           req_r, req_n_s;
   logic                           we_r, we_n_s;
   logic [DATA_WIDTH-1:0]          addr_r, addr_n_s;
   logic [DATA_WIDTH-1:0]          wdata_r, wdata_n_s;
   logic [3:0]                     wstrb_r, wstrb_n_s;
   logic                           fault_r, fault_n_s;
   logic                           err_r, err_n_s;
   logic [2:0]                     f3_hold_r, f3_hold_n_s;
   logic [1:0]                     off_hold_r, off_hold_n_s;
   logic                           store_hold_r, store_hold_n_s;
   logic [INST_WIDTH-1:0]          inst_hold_r, inst_hold_n_s;
   logic [REGISTER_ADDR_WIDTH-1:0] rd_hold_r, rd_hold_n_s;
   logic                           rw_hold_r, rw_hold_n_s;
   logic [INST_WIDTH-1:0]          inst_wb_r, inst_wb_n_s;
   logic                           rw_wb_r, rw_wb_n_s;
   logic [REGISTER_ADDR_WIDTH-1:0] rd_wb_r, rd_wb_n_s;
   logic [DATA_WIDTH-1:0]          wbd_wb_r, wbd_wb_n_s;

   logic       mem_op_s;
   logic       bad_s;
   logic       ack_s;
   logic       timeout_s;
   logic       stall_s;
   logic [2:0] funct3_s;
   logic [1:0] off_s;

   // Next-state, bus issue and MEM/WB capture decisions.
   always_comb begin
      funct3_s       = INST_MEM_i[14:12];
      off_s          = alu_res_MEM_i[1:0];
      mem_op_s       = mem_write_MEM_i | (result_sel_MEM_i == 2'b01);
      bad_s          = mem_op_s & (~f_funct3_ok(funct3_s, mem_write_MEM_i) |
                                   f_misaligned(funct3_s, off_s));
      ack_s          = (state_r == ST_WAIT) & dmem_ack_i;
      timeout_s      = (state_r == ST_WAIT) & ~dmem_ack_i & (timer_r == TIMEOUT_C);
      stall_s        = 1'b0;
      state_n_s      = state_r;
      timer_n_s      = timer_r;
      req_n_s        = req_r;
      we_n_s         = we_r;
      addr_n_s       = addr_r;
      wdata_n_s      = wdata_r;
      wstrb_n_s      = wstrb_r;
      fault_n_s      = 1'b0;
      err_n_s        = 1'b0;
      f3_hold_n_s    = f3_hold_r;
      off_hold_n_s   = off_hold_r;
      store_hold_n_s = store_hold_r;
      inst_hold_n_s  = inst_hold_r;
      rd_hold_n_s    = rd_hold_r;
      rw_hold_n_s    = rw_hold_r;
      inst_wb_n_s    = {INST_WIDTH{1'b0}};
      rw_wb_n_s      = 1'b0;
      rd_wb_n_s      = {REGISTER_ADDR_WIDTH{1'b0}};
      wbd_wb_n_s     = {DATA_WIDTH{1'b0}};

      case (state_r)
         ST_IDLE: begin
            if (!mem_op_s) begin
               inst_wb_n_s = INST_MEM_i;
               rw_wb_n_s   = reg_write_MEM_i;
               rd_wb_n_s   = rd_MEM_i;
               wbd_wb_n_s  = (result_sel_MEM_i == 2'b10) ? PC_plus_4_MEM_i : alu_res_MEM_i;
            end else if (bad_s) begin
               fault_n_s = 1'b1;
            end else begin
               stall_s        = 1'b1;
               state_n_s      = ST_WAIT;
               timer_n_s      = {TIMER_W{1'b0}};
               req_n_s        = 1'b1;
               we_n_s         = mem_write_MEM_i;
               addr_n_s       = {alu_res_MEM_i[DATA_WIDTH-1:2], 2'b00};
               f3_hold_n_s    = funct3_s;
               off_hold_n_s   = off_s;
               store_hold_n_s = mem_write_MEM_i;
               inst_hold_n_s  = INST_MEM_i;
               rd_hold_n_s    = rd_MEM_i;
               rw_hold_n_s    = reg_write_MEM_i;
               if (mem_write_MEM_i) begin
                  wdata_n_s = f_store_data(funct3_s, write_data_MEM_i);
                  wstrb_n_s = f_store_strb(funct3_s, off_s);
               end else begin
                  wdata_n_s = {DATA_WIDTH{1'b0}};
                  wstrb_n_s = 4'b0000;
               end
            end
         end
         ST_WAIT: begin
            if (ack_s) begin
               state_n_s   = ST_IDLE;
               timer_n_s   = {TIMER_W{1'b0}};
               req_n_s     = 1'b0;
               we_n_s      = 1'b0;
               wstrb_n_s   = 4'b0000;
               inst_wb_n_s = inst_hold_r;
               rd_wb_n_s   = rd_hold_r;
               if (store_hold_r) begin
                  rw_wb_n_s = 1'b0;
               end else begin
                  rw_wb_n_s  = rw_hold_r;
                  wbd_wb_n_s = f_load_data(f3_hold_r, dmem_rdata_i, off_hold_r);
               end
            end else if (timeout_s) begin
               state_n_s = ST_IDLE;
               timer_n_s = {TIMER_W{1'b0}};
               req_n_s   = 1'b0;
               we_n_s    = 1'b0;
               wstrb_n_s = 4'b0000;
               err_n_s   = 1'b1;
            end else begin
               stall_s   = 1'b1;
               timer_n_s = timer_r + TIMER_W'(1);
            end
         end
         default: begin
            state_n_s = ST_IDLE;
            timer_n_s = {TIMER_W{1'b0}};
            req_n_s   = 1'b0;
            we_n_s    = 1'b0;
            wstrb_n_s = 4'b0000;
         end
      endcase
   end

   // State, bus and MEM/WB registers.
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_r      <= ST_IDLE;
         timer_r      <= {TIMER_W{1'b0}};
         req_r        <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= {DATA_WIDTH{1'b0}};
         wdata_r      <= {DATA_WIDTH{1'b0}};
         wstrb_r      <= 4'b0000;
         fault_r      <= 1'b0;
         err_r        <= 1'b0;
         f3_hold_r    <= 3'b000;
         off_hold_r   <= 2'b00;
         store_hold_r <= 1'b0;
         inst_hold_r  <= {INST_WIDTH{1'b0}};
         rd_hold_r    <= {REGISTER_ADDR_WIDTH{1'b0}};
         rw_hold_r    <= 1'b0;
         inst_wb_r    <= {INST_WIDTH{1'b0}};
         rw_wb_r      <= 1'b0;
         rd_wb_r      <= {REGISTER_ADDR_WIDTH{1'b0}};
         wbd_wb_r     <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r      <= state_n_s;
         timer_r      <= timer_n_s;
         req_r        <= req_n_s;
         we_r         <= we_n_s;
         addr_r       <= addr_n_s;
         wdata_r      <= wdata_n_s;
         wstrb_r      <= wstrb_n_s;
         fault_r      <= fault_n_s;
         err_r        <= err_n_s;
         f3_hold_r    <= f3_hold_n_s;
         off_hold_r   <= off_hold_n_s;
         store_hold_r <= store_hold_n_s;
         inst_hold_r  <= inst_hold_n_s;
         rd_hold_r    <= rd_hold_n_s;
         rw_hold_r    <= rw_hold_n_s;
         inst_wb_r    <= inst_wb_n_s;
         rw_wb_r      <= rw_wb_n_s;
         rd_wb_r      <= rd_wb_n_s;
         wbd_wb_r     <= wbd_wb_n_s;
      end
   end

   assign mem_stall_o        = stall_s;
   assign dmem_req_o         = req_r;
   assign dmem_we_o          = we_r;
   assign dmem_addr_o        = addr_r;
   assign dmem_wdata_o       = wdata_r;
   assign dmem_wstrb_o       = wstrb_r;
   assign lsu_fault_o        = fault_r;
   assign dmem_err_o         = err_r;
   assign INST_MEM_WB_o      = inst_wb_r;
   assign reg_write_MEM_WB_o = rw_wb_r;
   assign rd_MEM_WB_o        = rd_wb_r;
   assign wb_data_MEM_WB_o   = wbd_wb_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios then random ops against an
// arithmetic reference model of load/store sizing, alignment and bus latency.
module tb_mem_stage_lsu;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n;
   logic [31:0] INST_MEM_i;
   logic        reg_write_MEM_i;
   logic        mem_write_MEM_i;
   logic [1:0]  result_sel_MEM_i;
   logic [31:0] alu_res_MEM_i;
   logic [4:0]  rd_MEM_i;
   logic [31:0] write_data_MEM_i;
   logic [31:0] PC_plus_4_MEM_i;
   logic        mem_stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        lsu_fault_o;
   logic        dmem_err_o;
   logic [31:0] INST_MEM_WB_o;
   logic        reg_write_MEM_WB_o;
   logic [4:0]  rd_MEM_WB_o;
   logic [31:0] wb_data_MEM_WB_o;

   int tests = 0;
   int fails = 0;
   int op_idx = 0;

   mem_stage_lsu #(.ACK_TIMEOUT(4)) dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
      .INST_MEM_i(INST_MEM_i), .reg_write_MEM_i(reg_write_MEM_i),
      .mem_write_MEM_i(mem_write_MEM_i), .result_sel_MEM_i(result_sel_MEM_i),
      .alu_res_MEM_i(alu_res_MEM_i), .rd_MEM_i(rd_MEM_i),
      .write_data_MEM_i(write_data_MEM_i), .PC_plus_4_MEM_i(PC_plus_4_MEM_i),
      .mem_stall_o(mem_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .lsu_fault_o(lsu_fault_o), .dmem_err_o(dmem_err_o),
      .INST_MEM_WB_o(INST_MEM_WB_o), .reg_write_MEM_WB_o(reg_write_MEM_WB_o),
      .rd_MEM_WB_o(rd_MEM_WB_o), .wb_data_MEM_WB_o(wb_data_MEM_WB_o)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s op%0d observed=%h expected=%h", tag, op_idx, obs, exp);
      end
   endtask

   // Access size in bytes, 0 for an unknown funct3.
   function automatic int unsigned size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit legal(input logic [2:0] f3, input bit st, input logic [31:0] a);
      int unsigned s;
      s = size_of(f3);
      if (s == 0) return 1'b0;
      if (st && f3 > 3'd2) return 1'b0;
      return (a % s) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      longint unsigned v, m;
      v = 64'(w) / (64'd1 << (8 * (a % 4)));
      m = 64'd1 << (8 * size_of(f3));
      v = v % m;
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= m / 2) v = v + (64'd1 << 32) - m;
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return (d % 256) * 32'h0101_0101;
         3'd1:    return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f3, input logic mw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] rdat, input int delay);
      logic [31:0] inst, pc4, exp_addr, exp_wb;
      logic [3:0]  exp_strb;
      logic [4:0]  rd;
      logic        rw;
      bit          mem_op, ok, done, tmo;
      int          stalls;
      inst = $urandom;
      inst[14:12] = f3;
      rd  = 5'($urandom);
      rw  = ($urandom_range(0, 3) != 0);
      pc4 = $urandom;
      op_idx++;
      INST_MEM_i = inst; reg_write_MEM_i = rw; mem_write_MEM_i = mw;
      result_sel_MEM_i = sel; alu_res_MEM_i = alu; rd_MEM_i = rd;
      write_data_MEM_i = wd; PC_plus_4_MEM_i = pc4; dmem_ack_i = 1'b0;
      dmem_rdata_i = $urandom;
      mem_op = mw || sel == 2'b01;
      ok = legal(f3, mw, alu);
      @(negedge cpu_clk);
      chk("stall_issue", 32'(mem_stall_o), 32'(mem_op && ok));
      @(posedge cpu_clk); #1;
      if (!mem_op || !ok) begin
         chk("fault", 32'(lsu_fault_o), 32'(mem_op));
         chk("req_idle", 32'(dmem_req_o), 32'd0);
         if (mem_op) begin
            chk("fault_bubble_inst", INST_MEM_WB_o, 32'd0);
            chk("fault_bubble_rw", 32'(reg_write_MEM_WB_o), 32'd0);
         end else begin
            exp_wb = (sel == 2'b10) ? pc4 : alu;
            chk("alu_inst", INST_MEM_WB_o, inst);
            chk("alu_rd", 32'(rd_MEM_WB_o), 32'(rd));
            chk("alu_rw", 32'(reg_write_MEM_WB_o), 32'(rw));
            chk("alu_wb", wb_data_MEM_WB_o, exp_wb);
         end
         return;
      end
      exp_addr = alu - (alu % 4);
      exp_strb = mw ? 4'(((32'd1 << size_of(f3)) - 32'd1) << (alu % 4)) : 4'd0;
      chk("issue_req", 32'(dmem_req_o), 32'd1);
      chk("issue_we", 32'(dmem_we_o), 32'(mw));
      chk("issue_addr", dmem_addr_o, exp_addr);
      chk("issue_strb", 32'(dmem_wstrb_o), 32'(exp_strb));
      if (mw) chk("issue_wdata", dmem_wdata_o, model_wdata(f3, wd));
      chk("issue_bubble", {INST_MEM_WB_o[30:0], reg_write_MEM_WB_o}, 32'd0);
      stalls = 1; done = 0; tmo = 0;
      for (int k = 0; k <= 4 && !done; k++) begin
         if (k == delay) begin
            dmem_ack_i = 1'b1; dmem_rdata_i = rdat;
         end else begin
            dmem_rdata_i = $urandom;
         end
         @(negedge cpu_clk);
         chk("wait_hold", 32'(dmem_req_o && dmem_addr_o == exp_addr && dmem_we_o == mw &&
                              dmem_wstrb_o == exp_strb), 32'd1);
         if (mem_stall_o) stalls++;
         if (k == delay) done = 1;
         else if (k == 4) begin done = 1; tmo = 1; end
         @(posedge cpu_clk); #1;
         dmem_ack_i = 1'b0;
      end
      chk("stall_cycles", 32'(stalls), tmo ? 32'd5 : 32'(delay + 1));
      chk("req_drop", 32'(dmem_req_o), 32'd0);
      chk("bus_err", 32'(dmem_err_o), 32'(tmo));
      if (tmo) begin
         chk("tmo_bubble_inst", INST_MEM_WB_o, 32'd0);
         chk("tmo_bubble_rw", 32'(reg_write_MEM_WB_o), 32'd0);
      end else begin
         chk("ret_inst", INST_MEM_WB_o, inst);
         chk("ret_rw", 32'(reg_write_MEM_WB_o), mw ? 32'd0 : 32'(rw));
         if (!mw) begin
            chk("ret_rd", 32'(rd_MEM_WB_o), 32'(rd));
            chk("ret_load", wb_data_MEM_WB_o, model_load(f3, alu, rdat));
         end
      end
   endtask

   initial begin
      int f3_tbl[5];
      logic [2:0]  f3;
      logic [1:0]  sel;
      logic        mw;
      logic [31:0] a;
      f3_tbl = '{0, 1, 2, 4, 5};
      cpu_rst_n = 1'b0;
      INST_MEM_i = 32'd0; reg_write_MEM_i = 1'b0; mem_write_MEM_i = 1'b0;
      result_sel_MEM_i = 2'b00; alu_res_MEM_i = 32'd0; rd_MEM_i = 5'd0;
      write_data_MEM_i = 32'd0; PC_plus_4_MEM_i = 32'd0;
      dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
      #2;
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_bus", dmem_addr_o | dmem_wdata_o | 32'(dmem_wstrb_o) | 32'(dmem_we_o), 32'd0);
      chk("rst_flags", 32'({lsu_fault_o, dmem_err_o, mem_stall_o}), 32'd0);
      chk("rst_wb", INST_MEM_WB_o | wb_data_MEM_WB_o | 32'(rd_MEM_WB_o) |
                    32'(reg_write_MEM_WB_o), 32'd0);
      #10 cpu_rst_n = 1'b1;
      @(posedge cpu_clk); #1;

      run_op(3'd0, 1'b0, 2'b00, 32'h0000_0010, 32'd0, 32'd0, 0);          // add
      run_op(3'd0, 1'b0, 2'b01, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 3);  // LB
      run_op(3'd4, 1'b0, 2'b01, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 3);  // LBU
      run_op(3'd1, 1'b1, 2'b00, 32'h0000_2002, 32'hABCD_1234, 32'd0, 0);  // SH
      run_op(3'd2, 1'b0, 2'b01, 32'h0000_3001, 32'd0, 32'd0, 0);          // LW misaligned
      run_op(3'd2, 1'b0, 2'b01, 32'h0000_4000, 32'd0, 32'd0, 5);          // timeout
      run_op(3'd5, 1'b0, 2'b01, 32'h0000_4002, 32'd0, 32'h8001_7FFF, 4);  // ack at limit
      run_op(3'd0, 1'b0, 2'b10, 32'h1234_5678, 32'd0, 32'd0, 0);          // link
      run_op(3'd4, 1'b1, 2'b01, 32'h0000_5000, 32'd0, 32'd0, 0);          // SBU illegal

      // Reset during WAIT abandons the access; a later ack is ignored.
      op_idx++;
      INST_MEM_i = 32'h0000_2003; mem_write_MEM_i = 1'b0; result_sel_MEM_i = 2'b01;
      reg_write_MEM_i = 1'b1; alu_res_MEM_i = 32'h0000_5000; rd_MEM_i = 5'd7;
      @(posedge cpu_clk); #1;
      chk("rw_req_up", 32'(dmem_req_o), 32'd1);
      @(posedge cpu_clk); #1;
      cpu_rst_n = 1'b0;
      INST_MEM_i = 32'd0; reg_write_MEM_i = 1'b0; result_sel_MEM_i = 2'b00;
      alu_res_MEM_i = 32'd0; rd_MEM_i = 5'd0;
      #1;
      chk("rw_req_drop", 32'(dmem_req_o), 32'd0);
      chk("rw_bus_zero", dmem_addr_o | 32'(dmem_wstrb_o) | 32'(dmem_we_o), 32'd0);
      chk("rw_wb_zero", INST_MEM_WB_o | 32'(reg_write_MEM_WB_o) | wb_data_MEM_WB_o, 32'd0);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      @(posedge cpu_clk); #1;
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      @(negedge cpu_clk);
      chk("rw_late_stall", 32'(mem_stall_o), 32'd0);
      @(posedge cpu_clk); #1;
      dmem_ack_i = 1'b0;
      chk("rw_late_req", 32'(dmem_req_o), 32'd0);
      chk("rw_late_rw", 32'(reg_write_MEM_WB_o), 32'd0);
      chk("rw_late_wb", wb_data_MEM_WB_o, 32'd0);

      for (int n = 0; n < 80; n++) begin
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(f3_tbl[$urandom_range(0, 4)]);
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         case ($urandom_range(0, 2))
            0: begin
               mw  = 1'b0;
               sel = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11);
            end
            1:       begin mw = 1'b0; sel = 2'b01; end
            default: begin mw = 1'b1; sel = 2'($urandom); end
         endcase
         run_op(f3, mw, sel, a, $urandom, $urandom, int'($urandom_range(0, 5)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
